// File: rtl/cnn_pkg.sv
// Shared types and clamp helpers for the CNN accelerator output path.
package cnn_pkg;

  localparam int unsigned ACC_W_DEF = 20;
  localparam int unsigned WO_DEF    = 8;
  localparam int unsigned CLAMP_W   = 64;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic signed [CLAMP_W-1:0] val;
    logic                      sat;
  } clamp_t;

  // Unsigned clamp to [0, 2^wo-1]; zeroing a negative does not count as saturation.
  function automatic clamp_t clamp_u(input logic signed [CLAMP_W-1:0] x,
                                     input int unsigned wo);
    logic signed [CLAMP_W-1:0] hi;
    clamp_t r;
    hi    = (CLAMP_W'(1) <<< wo) - CLAMP_W'(1);
    r.val = x;
    r.sat = 1'b0;
    if (x[CLAMP_W-1]) begin
      r.val = '0;
    end else if (x > hi) begin
      r.val = hi;
      r.sat = 1'b1;
    end
    return r;
  endfunction

  // Signed clamp to [-2^(wo-1), 2^(wo-1)-1]; both limits count as saturation.
  function automatic clamp_t clamp_s(input logic signed [CLAMP_W-1:0] x,
                                     input int unsigned wo);
    logic signed [CLAMP_W-1:0] hi;
    logic signed [CLAMP_W-1:0] lo;
    clamp_t r;
    hi    = (CLAMP_W'(1) <<< (wo - 1)) - CLAMP_W'(1);
    lo    = -(CLAMP_W'(1) <<< (wo - 1));
    r.val = x;
    r.sat = 1'b0;
    if (x < lo) begin
      r.val = lo;
      r.sat = 1'b1;
    end else if (x > hi) begin
      r.val = hi;
      r.sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/quant_pipe.sv
// Two-stage requantisation datapath: round-half-up shift, then clamp/offset to WO bits.
module quant_pipe
  import cnn_pkg::*;
#(
  parameter int unsigned ACC_W   = ACC_W_DEF,
  parameter int unsigned WO      = WO_DEF,
  parameter int unsigned SHIFT   = 4,
  parameter int unsigned RELU_EN = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_vld,
  input  logic signed [ACC_W-1:0] in_data,
  output logic                    s1_vld,
  output logic                    out_vld,
  output logic [WO-1:0]           out_data,
  output logic                    out_sat
);

  localparam int unsigned RW = ACC_W + 1;
  localparam logic signed [CLAMP_W-1:0] OFFSET = CLAMP_W'(1) <<< (WO - 1);

  logic signed [RW-1:0] ext_c;
  logic signed [RW-1:0] rnd_c;
  logic signed [RW-1:0] s1_data;
  clamp_t               cl_c;
  logic [WO-1:0]        pix_c;

  assign ext_c = RW'(in_data);

  // One guard bit keeps the rounding add from overflowing.
  generate
    if (SHIFT == 0) begin : g_noshift
      assign rnd_c = ext_c;
    end else begin : g_shift
      localparam logic signed [RW-1:0] HALF = RW'(1) <<< (SHIFT - 1);
      logic signed [RW-1:0] sum_c;
      assign sum_c = ext_c + HALF;
      assign rnd_c = sum_c >>> SHIFT;
    end
  endgenerate

  always_comb begin
    cl_c  = '0;
    pix_c = '0;
    if (RELU_EN != 0) begin
      cl_c  = clamp_u(CLAMP_W'(s1_data), WO);
      pix_c = WO'(cl_c.val);
    end else begin
      cl_c  = clamp_s(CLAMP_W'(s1_data), WO);
      pix_c = WO'(cl_c.val + OFFSET);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_vld   <= 1'b0;
      s1_data  <= '0;
      out_vld  <= 1'b0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      s1_vld  <= in_vld;
      out_vld <= s1_vld;
      out_sat <= s1_vld & cl_c.sat;
      if (in_vld) s1_data  <= rnd_c;
      if (s1_vld) out_data <= pix_c;
    end
  end

endmodule

// File: rtl/conv_out_quantizer.sv
// Conv output stage: frame FSM, pixel counter and saturation count around quant_pipe.
module conv_out_quantizer
  import cnn_pkg::*;
#(
  parameter int unsigned ACC_W   = ACC_W_DEF,
  parameter int unsigned WO      = WO_DEF,
  parameter int unsigned SHIFT   = 4,
  parameter int unsigned RELU_EN = 1,
  parameter int unsigned WIDTH   = 128,
  parameter int unsigned HEIGHT  = 128
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [ACC_W-1:0] in_data,
  output logic                    out_vld,
  output logic [WO-1:0]           out_data,
  output logic                    busy,
  output logic                    frame_done,
  output logic [15:0]             sat_cnt
);

  localparam int unsigned FRAME_SIZE = WIDTH * HEIGHT;
  localparam int unsigned CNT_W      = $clog2(FRAME_SIZE + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(FRAME_SIZE - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] pix_cnt;
  logic             accept_c;
  logic             start_go_c;
  logic             s1_vld;
  logic             out_sat;

  assign accept_c   = in_valid & in_ready;
  // A start landing on the frame_done cycle belongs to the old frame and is dropped.
  assign start_go_c = start & (state == IDLE) & ~frame_done;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_go_c) state_nxt = RUN;
      RUN:     if (accept_c && pix_cnt == LAST) state_nxt = DRAIN;
      DRAIN:   if (!s1_vld) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state)
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      DRAIN:   busy = 1'b1;
      default: ;
    endcase
  end

  // Pipeline is empty when the last word has reached the output stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) frame_done <= 1'b0;
    else       frame_done <= (state == DRAIN) & ~s1_vld;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pix_cnt <= '0;
      sat_cnt <= '0;
    end else begin
      if (start_go_c)    pix_cnt <= '0;
      else if (accept_c) pix_cnt <= pix_cnt + CNT_W'(1);
      if (start_go_c)
        sat_cnt <= '0;
      else if (out_vld && out_sat && sat_cnt != 16'hFFFF)
        sat_cnt <= sat_cnt + 16'd1;
    end
  end

  quant_pipe #(
    .ACC_W   (ACC_W),
    .WO      (WO),
    .SHIFT   (SHIFT),
    .RELU_EN (RELU_EN)
  ) u_pipe (
    .clk      (clk),
    .rstn     (rstn),
    .in_vld   (accept_c),
    .in_data  (in_data),
    .s1_vld   (s1_vld),
    .out_vld  (out_vld),
    .out_data (out_data),
    .out_sat  (out_sat)
  );

endmodule
